// File: rtl/uart_rx_fifo_sb_ctrl.sv
// Bus-attached UART receiver: synchronised serial input, runtime-programmable framing,
// receive FIFO with sticky error flags and a level interrupt.
module uart_rx_fifo_sb_ctrl #(
   parameter int CLK_FREQ     = 10_000_000,
   parameter int DEFAULT_BAUD = 9600,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic        req_i,
   input  logic [31:0] WD_i,
   input  logic        WE_i,
   output logic [31:0] RD_o,
   input  logic        rx_i,
   output logic        irq_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ / DEFAULT_BAUD);
   localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t state_q, state_d;
   logic sync1_q, sync2_q, rxPrev_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0] bitIdx_q, bitIdx_d;
   logic stopIdx_q, stopIdx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic pendPar_q, pendPar_d, pendFrm_q, pendFrm_d;
   logic [15:0] shDiv_q, shDiv_d;
   logic [1:0] shPar_q, shPar_d;
   logic shStop_q, shStop_d;
   logic [15:0] div_q, div_d;
   logic [1:0] par_q, par_d;
   logic stop_q, stop_d;
   logic [2:0] err_q, err_d, setErr;
   logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0] rd_q, rd_d;
   logic irq_q, irq_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic [5:0] addr;
   logic busWr, busRd, pop, push, pushEff, softRst, full, fall, sample, parEn, frmNow;
   logic unusedBits;

   assign addr       = addr_i[5:0];
   assign busWr      = req_i & WE_i;
   assign busRd      = req_i & ~WE_i;
   assign pop        = busRd && (addr == 6'h00) && (count_q != '0);
   assign softRst    = busWr && (addr == 6'h24) && WD_i[0];
   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign fall       = rxPrev_q & ~sync2_q;
   assign sample     = (cnt_q == 16'd0);
   assign parEn      = (shPar_q == 2'd1) || (shPar_q == 2'd2);
   assign frmNow     = pendFrm_q | ~sync2_q;
   assign pushEff    = push & ~softRst;
   assign unusedBits = ^{addr_i[31:6], WD_i[31:16]};
   assign RD_o       = rd_q;
   assign irq_o      = irq_q;

   // Synchroniser and previous-sample flop idle high so reset never looks like a start bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         rxPrev_q <= 1'b1;
      end else begin
         sync1_q  <= rx_i;
         sync2_q  <= sync1_q;
         rxPrev_q <= sync2_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bitIdx_d  = bitIdx_q;
      stopIdx_d = stopIdx_q;
      shift_d   = shift_q;
      pendPar_d = pendPar_q;
      pendFrm_d = pendFrm_q;
      shDiv_d   = shDiv_q;
      shPar_d   = shPar_q;
      shStop_d  = shStop_q;
      push      = 1'b0;
      setErr    = 3'b000;
      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d   = S_START;
               cnt_d     = {1'b0, div_q[15:1]} - 16'd1;
               shDiv_d   = div_q;
               shPar_d   = par_q;
               shStop_d  = stop_q;
               bitIdx_d  = 3'd0;
               stopIdx_d = 1'b0;
               pendPar_d = 1'b0;
               pendFrm_d = 1'b0;
            end
         end
         S_START: begin
            if (!sample) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               cnt_d   = shDiv_q - 16'd1;
               state_d = sync2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (!sample) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               cnt_d   = shDiv_q - 16'd1;
               shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
               if (bitIdx_q == BIT_LAST) begin
                  state_d = parEn ? S_PARITY : S_STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (!sample) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               cnt_d   = shDiv_q - 16'd1;
               state_d = S_STOP;
               if (sync2_q != ((^shift_q) ^ (shPar_q == 2'd2))) begin
                  pendPar_d = 1'b1;
               end
            end
         end
         S_STOP: begin
            if (!sample) begin
               cnt_d = cnt_q - 16'd1;
            end else if (stopIdx_q != shStop_q) begin
               cnt_d     = shDiv_q - 16'd1;
               stopIdx_d = 1'b1;
               pendFrm_d = frmNow;
            end else begin
               // Last stop sample: the frame is committed or discarded right here.
               state_d = S_IDLE;
               if (pendPar_q || frmNow) begin
                  setErr = {1'b0, frmNow, pendPar_q};
               end else if (full && !pop) begin
                  setErr = 3'b100;
               end else begin
                  push = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (softRst) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      div_d   = div_q;
      par_d   = par_q;
      stop_d  = stop_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      err_d   = (err_q & ~((busWr && addr == 6'h1C) ? WD_i[2:0] : 3'b000)) | setErr;
      rd_d    = rd_q;
      if (busWr) begin
         case (addr)
            6'h0C: div_d  = (WD_i[15:0] < 16'd4) ? 16'd4 : WD_i[15:0];
            6'h10: par_d  = WD_i[1:0];
            6'h14: stop_d = WD_i[0];
            default: ;
         endcase
      end
      if (pushEff) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(pushEff) - CW'(pop);
      if (softRst) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
         err_d   = 3'b000;
      end
      if (busRd) begin
         case (addr)
            6'h00: rd_d = (count_q != '0) ? 32'(mem_q[rptr_q]) : 32'd0;
            6'h04: rd_d = 32'(count_q != '0);
            6'h08: rd_d = 32'(state_q != S_IDLE);
            6'h0C: rd_d = 32'(div_q);
            6'h10: rd_d = 32'(par_q);
            6'h14: rd_d = 32'(stop_q);
            6'h18: rd_d = 32'(count_q);
            6'h1C: rd_d = 32'(err_q);
            default: rd_d = 32'd0;
         endcase
      end
      irq_d = (count_d != '0) || (err_d != 3'b000);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         bitIdx_q  <= 3'd0;
         stopIdx_q <= 1'b0;
         shift_q   <= '0;
         pendPar_q <= 1'b0;
         pendFrm_q <= 1'b0;
         shDiv_q   <= DIV_RESET;
         shPar_q   <= 2'd0;
         shStop_q  <= 1'b0;
         div_q     <= DIV_RESET;
         par_q     <= 2'd0;
         stop_q    <= 1'b0;
         err_q     <= 3'b000;
         rptr_q    <= '0;
         wptr_q    <= '0;
         count_q   <= '0;
         rd_q      <= 32'd0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bitIdx_q  <= bitIdx_d;
         stopIdx_q <= stopIdx_d;
         shift_q   <= shift_d;
         pendPar_q <= pendPar_d;
         pendFrm_q <= pendFrm_d;
         shDiv_q   <= shDiv_d;
         shPar_q   <= shPar_d;
         shStop_q  <= shStop_d;
         div_q     <= div_d;
         par_q     <= par_d;
         stop_q    <= stop_d;
         err_q     <= err_d;
         rptr_q    <= rptr_d;
         wptr_q    <= wptr_d;
         count_q   <= count_d;
         rd_q      <= rd_d;
         irq_q     <= irq_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (pushEff) begin
         mem_q[wptr_q] <= shift_q;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_sb_ctrl.sv
// Directed bench for uart_rx_fifo_sb_ctrl: serial frames in, register reads checked
// with immediate assertions against hand-computed values.
module tb_uart_rx_fifo_sb_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = 32'd0;
   logic        req = 1'b0;
   logic [31:0] wd = 32'd0;
   logic        we = 1'b0;
   logic [31:0] rd;
   logic        rx = 1'b1;
   logic        irq;
   int          checkCount = 0;
   int          failCount = 0;
   logic [31:0] data;

   uart_rx_fifo_sb_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .addr_i(addr),
      .req_i (req),
      .WD_i  (wd),
      .WE_i  (we),
      .RD_o  (rd),
      .rx_i  (rx),
      .irq_o (irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wd = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      req = 1'b0;
      d = rd;
   endtask

   task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] expected);
      logic [31:0] v;
      busRead(a, v);
      checkOutput(tag, v, expected);
   endtask

   // One serial frame, LSB first, optional parity bit, then stop bit(s) and a short idle gap.
   task automatic applyStimulus(input logic [7:0] d, input bit withPar, input logic parBit,
                                input int nStop, input logic stopVal, input int bitCycles);
      @(negedge clk);
      rx = 1'b0;
      repeat (bitCycles) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (bitCycles) @(negedge clk);
      end
      if (withPar) begin
         rx = parBit;
         repeat (bitCycles) @(negedge clk);
      end
      rx = stopVal;
      repeat (bitCycles) @(negedge clk);
      if (nStop == 2) begin
         rx = 1'b1;
         repeat (bitCycles) @(negedge clk);
      end
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      checkOutput("reset_rd", rd, 32'd0);
      readCheck("reset_div", 32'h0C, 32'd1041);
      readCheck("reset_valid", 32'h04, 32'd0);
      readCheck("reset_count", 32'h18, 32'd0);
      checkOutput("reset_irq_idle", {31'd0, irq}, 32'd0);

      $display("[TB] 0xA5 8N1 at default divisor");
      applyStimulus(8'hA5, 1'b0, 1'b0, 1, 1'b1, 1041);
      checkOutput("a5_irq", {31'd0, irq}, 32'd1);
      readCheck("a5_count", 32'h18, 32'd1);
      readCheck("a5_valid", 32'h04, 32'd1);
      readCheck("a5_data", 32'h00, 32'h0000_00A5);
      checkOutput("a5_irq_after_pop", {31'd0, irq}, 32'd0);
      readCheck("a5_count_after_pop", 32'h18, 32'd0);
      readCheck("empty_pop", 32'h00, 32'd0);

      busWrite(32'h0C, 32'd2);
      readCheck("div_clamp", 32'h0C, 32'd4);
      busWrite(32'h0C, 32'd16);
      readCheck("div_16", 32'h0C, 32'd16);
      readCheck("unmapped", 32'h20, 32'd0);

      $display("[TB] parity and framing errors");
      busWrite(32'h10, 32'd1);
      applyStimulus(8'h03, 1'b1, 1'b1, 1, 1'b1, 16);
      readCheck("par_count", 32'h18, 32'd0);
      readCheck("par_err", 32'h1C, 32'h1);
      checkOutput("par_irq", {31'd0, irq}, 32'd1);
      busWrite(32'h1C, 32'h1);
      readCheck("par_err_clr", 32'h1C, 32'h0);
      checkOutput("par_irq_clr", {31'd0, irq}, 32'd0);
      applyStimulus(8'h03, 1'b1, 1'b0, 1, 1'b0, 16);
      readCheck("frm_err", 32'h1C, 32'h2);
      readCheck("frm_count", 32'h18, 32'd0);
      applyStimulus(8'h03, 1'b1, 1'b0, 1, 1'b1, 16);
      readCheck("par_good_count", 32'h18, 32'd1);
      busWrite(32'h24, 32'h1);
      readCheck("softrst_count", 32'h18, 32'd0);
      readCheck("softrst_err", 32'h1C, 32'h0);
      readCheck("softrst_par_kept", 32'h10, 32'd1);
      checkOutput("softrst_irq", {31'd0, irq}, 32'd0);
      busWrite(32'h10, 32'd0);

      $display("[TB] overrun with nine frames");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(8'(8'h10 + i), 1'b0, 1'b0, 1, 1'b1, 16);
      end
      readCheck("ovr_count", 32'h18, 32'd8);
      readCheck("ovr_err", 32'h1C, 32'h4);
      for (int i = 0; i < 8; i++) begin
         readCheck($sformatf("ovr_data%0d", i), 32'h00, 32'h10 + 32'(i));
      end
      readCheck("ovr_ninth", 32'h00, 32'd0);
      busWrite(32'h1C, 32'h7);
      readCheck("ovr_err_clr", 32'h1C, 32'h0);

      $display("[TB] two stop bits");
      busWrite(32'h14, 32'd1);
      applyStimulus(8'h3C, 1'b0, 1'b0, 2, 1'b1, 16);
      readCheck("stop2_data", 32'h00, 32'h3C);
      busWrite(32'h14, 32'd0);

      $display("[TB] glitch shorter than half a bit");
      @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      readCheck("glitch_busy", 32'h08, 32'd0);
      readCheck("glitch_count", 32'h18, 32'd0);
      readCheck("glitch_err", 32'h1C, 32'd0);

      $display("[TB] reset in the middle of data bit 4");
      applyStimulus(8'h77, 1'b0, 1'b0, 1, 1'b1, 16);
      busWrite(32'h10, 32'd2);
      busWrite(32'h14, 32'd1);
      @(negedge clk);
      rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (16) @(negedge clk);
      end
      rx = 1'b1;
      busRead(32'h08, data);
      checkOutput("midframe_busy", data, 32'd1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      readCheck("rst_count", 32'h18, 32'd0);
      readCheck("rst_busy", 32'h08, 32'd0);
      readCheck("rst_div", 32'h0C, 32'd1041);
      readCheck("rst_par", 32'h10, 32'd0);
      readCheck("rst_stop", 32'h14, 32'd0);
      readCheck("rst_err", 32'h1C, 32'd0);
      applyStimulus(8'h5A, 1'b0, 1'b0, 1, 1'b1, 1041);
      readCheck("post_rst_count", 32'h18, 32'd1);
      readCheck("post_rst_data", 32'h00, 32'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
